// File: rtl/sysid_arb_pkg.sv
// Shared definitions for the two-master sysid read arbiter.
// Holds the FSM state encoding, the default data width and the legal slave latency range.
// The latency clamp keeps counter sizing sane if an out-of-range value is ever passed in.
package sysid_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        ACCEPT = 2'd2
    } arb_state_t;

    localparam int DATA_W_DEFAULT    = 32;
    localparam int SLAVE_LATENCY_MIN = 1;
    localparam int SLAVE_LATENCY_MAX = 15;

    // Force a requested slave latency into the supported range.
    function automatic int clamp_latency(input int lat);
        if (lat < SLAVE_LATENCY_MIN) begin
            return SLAVE_LATENCY_MIN;
        end
        if (lat > SLAVE_LATENCY_MAX) begin
            return SLAVE_LATENCY_MAX;
        end
        return lat;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection, purely combinational.
// Latency: zero cycles, grant follows req_i and last_grant_i directly.
// Backpressure: none; the caller decides when a grant is acted upon.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,   // index of the master served most recently
    output logic [1:0] grant_o         // one-hot, all zero when nobody requests
);

    // A lone requester always wins; on a tie the master not served last wins.
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/sysid_read_arbiter.sv
// Shares one sysid slave (system ID / timestamp words) between two Avalon-MM read masters.
// Latency: read sampled in IDLE -> readdatavalid after SLAVE_LATENCY+2 cycles.
// Backpressure: waitrequest stays high except for the single ACCEPT cycle of the granted master.
module sysid_read_arbiter #(
    parameter int DATA_W        = sysid_arb_pkg::DATA_W_DEFAULT,
    parameter int SLAVE_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_read,
    input  logic              m0_address,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_read,
    input  logic              m1_address,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              s_address,
    input  logic [DATA_W-1:0] s_readdata
);

    import sysid_arb_pkg::*;

    // The counter must be able to hold LAT itself so it can saturate there.
    localparam int               LAT      = sysid_arb_pkg::clamp_latency(SLAVE_LATENCY);
    localparam int               CNT_W    = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LAT);

    arb_state_t        state_q;
    logic              gnt_q;          // master currently being served
    logic              last_q;         // master served most recently (completed reads only)
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              s_address_q;
    logic [1:0]        wait_q;
    logic [1:0]        rdv_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              gnt_addr_d;
    logic              gnt_read;

    assign req = {m1_read, m0_read};

    rr_arbiter2 u_rr (
        .req_i        (req),
        .last_grant_i (last_q),
        .grant_o      (grant)
    );

    assign gnt_addr_d = grant[1] ? m1_address : m0_address;
    assign gnt_read   = gnt_q ? m1_read : m0_read;
    assign cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Transaction FSM with registered outputs; valid/waitrequest default to their idle values each cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            s_address_q <= 1'b0;
            wait_q      <= 2'b11;
            rdv_q       <= 2'b00;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            rdv_q  <= 2'b00;
            wait_q <= 2'b11;
            case (state_q)
                IDLE: begin
                    // Also reached on the readdatavalid cycle, so back-to-back grants work.
                    if (grant != 2'b00) begin
                        gnt_q       <= grant[1];
                        s_address_q <= gnt_addr_d;
                        cnt_q       <= '0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!gnt_read) begin
                        // Master withdrew its read mid-flight: drop it without touching fairness state.
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ACCEPT;
                        wait_q  <= gnt_q ? 2'b01 : 2'b10;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ACCEPT: begin
                    if (gnt_q) begin
                        rdata1_q <= s_readdata;
                    end else begin
                        rdata0_q <= s_readdata;
                    end
                    rdv_q   <= gnt_q ? 2'b10 : 2'b01;
                    last_q  <= gnt_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_address        = s_address_q;
    assign m0_waitrequest   = wait_q[0];
    assign m1_waitrequest   = wait_q[1];
    assign m0_readdatavalid = rdv_q[0];
    assign m1_readdatavalid = rdv_q[1];
    assign m0_readdata      = rdata0_q;
    assign m1_readdata      = rdata1_q;

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Directed bench for sysid_read_arbiter: one instance at SLAVE_LATENCY=1, one at 4.
// The slave is modelled as a combinational mux on s_address.
// Cycle 0 is the cycle in which read is first presented while the FSM is idle.
module tb_sysid_read_arbiter;

    localparam logic [31:0] ID_WORD = 32'h513FEADB;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    // Instance A: SLAVE_LATENCY = 1
    logic        a_m0_read, a_m0_address, a_m1_read, a_m1_address;
    logic        a_m0_wr, a_m1_wr, a_m0_rdv, a_m1_rdv, a_s_address;
    logic [31:0] a_m0_rd, a_m1_rd, a_s_rd;
    assign a_s_rd = a_s_address ? ID_WORD : 32'h0;

    // Instance B: SLAVE_LATENCY = 4
    logic        b_m0_read, b_m0_address, b_m1_read, b_m1_address;
    logic        b_m0_wr, b_m1_wr, b_m0_rdv, b_m1_rdv, b_s_address;
    logic [31:0] b_m0_rd, b_m1_rd, b_s_rd;
    assign b_s_rd = b_s_address ? ID_WORD : 32'h0;

    sysid_read_arbiter #(.DATA_W(32), .SLAVE_LATENCY(1)) u_a (
        .clock            (clock),
        .reset            (reset),
        .m0_read          (a_m0_read),
        .m0_address       (a_m0_address),
        .m0_waitrequest   (a_m0_wr),
        .m0_readdata      (a_m0_rd),
        .m0_readdatavalid (a_m0_rdv),
        .m1_read          (a_m1_read),
        .m1_address       (a_m1_address),
        .m1_waitrequest   (a_m1_wr),
        .m1_readdata      (a_m1_rd),
        .m1_readdatavalid (a_m1_rdv),
        .s_address        (a_s_address),
        .s_readdata       (a_s_rd)
    );

    sysid_read_arbiter #(.DATA_W(32), .SLAVE_LATENCY(4)) u_b (
        .clock            (clock),
        .reset            (reset),
        .m0_read          (b_m0_read),
        .m0_address       (b_m0_address),
        .m0_waitrequest   (b_m0_wr),
        .m0_readdata      (b_m0_rd),
        .m0_readdatavalid (b_m0_rdv),
        .m1_read          (b_m1_read),
        .m1_address       (b_m1_address),
        .m1_waitrequest   (b_m1_wr),
        .m1_readdata      (b_m1_rd),
        .m1_readdatavalid (b_m1_rdv),
        .s_address        (b_s_address),
        .s_readdata       (b_s_rd)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // The two readdatavalid outputs of an instance must never be high together.
    always @(negedge clock) begin
        chk("rdv_excl_a", 32'(a_m0_rdv & a_m1_rdv), 32'd0);
        chk("rdv_excl_b", 32'(b_m0_rdv & b_m1_rdv), 32'd0);
    end

    initial begin
        logic adr;
        reset = 1'b1;
        a_m0_read = 0; a_m0_address = 0; a_m1_read = 0; a_m1_address = 0;
        b_m0_read = 0; b_m0_address = 0; b_m1_read = 0; b_m1_address = 0;

        // ---- reset values
        #12;
        chk("rst_a_m0_wr",   a_m0_wr, 1);
        chk("rst_a_m1_wr",   a_m1_wr, 1);
        chk("rst_a_m0_rdv",  a_m0_rdv, 0);
        chk("rst_a_m1_rdv",  a_m1_rdv, 0);
        chk("rst_a_m0_data", a_m0_rd, 0);
        chk("rst_a_m1_data", a_m1_rd, 0);
        chk("rst_a_saddr",   a_s_address, 0);
        chk("rst_b_m1_wr",   b_m1_wr, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick;

        // ---- single read of the timestamp word by m0
        a_m0_read = 1; a_m0_address = 1;
        tick; // c1
        chk("t1_c1_wr", a_m0_wr, 1);
        chk("t1_c1_saddr", a_s_address, 1);
        tick; // c2
        chk("t1_c2_m0wr", a_m0_wr, 0);
        chk("t1_c2_m1wr", a_m1_wr, 1);
        chk("t1_c2_rdv", a_m0_rdv, 0);
        a_m0_read = 0;
        tick; // c3
        chk("t1_c3_rdv", a_m0_rdv, 1);
        chk("t1_c3_data", a_m0_rd, ID_WORD);
        chk("t1_c3_wr", a_m0_wr, 1);
        tick; // c4
        chk("t1_c4_rdv", a_m0_rdv, 0);
        chk("t1_c4_hold", a_m0_rd, ID_WORD);

        // ---- reset asserted during ACCEPT
        a_m0_read = 1; a_m0_address = 1;
        tick; tick; // c2 ACCEPT
        chk("t2_c2_wr", a_m0_wr, 0);
        a_m0_read = 0;
        #2 reset = 1'b1;
        #1;
        chk("t2_rst_wr", a_m0_wr, 1);
        chk("t2_rst_data", a_m0_rd, 0);
        chk("t2_rst_saddr", a_s_address, 0);
        chk("t2_rst_rdv", a_m0_rdv, 0);
        tick;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t2_no_rdv", a_m0_rdv, 0);
        end

        // ---- collision after reset: m0 first, then m1 wins while m0 keeps requesting
        a_m0_read = 1; a_m0_address = 1; a_m1_read = 1; a_m1_address = 1;
        tick; // c1
        chk("t3_c1_m0wr", a_m0_wr, 1);
        tick; // c2
        chk("t3_c2_m0wr", a_m0_wr, 0);
        chk("t3_c2_m1wr", a_m1_wr, 1);
        tick; // c3
        chk("t3_c3_m0rdv", a_m0_rdv, 1);
        chk("t3_c3_m0data", a_m0_rd, ID_WORD);
        chk("t3_c3_m1rdv", a_m1_rdv, 0);
        tick; tick; // c5
        chk("t3_c5_m1wr", a_m1_wr, 0);
        chk("t3_c5_m0wr", a_m0_wr, 1);
        a_m1_read = 0;
        tick; // c6
        chk("t3_c6_m1rdv", a_m1_rdv, 1);
        chk("t3_c6_m1data", a_m1_rd, ID_WORD);
        chk("t3_c6_m0rdv", a_m0_rdv, 0);
        tick; tick; // c8
        chk("t3_c8_m0wr", a_m0_wr, 0);
        a_m0_read = 0;
        tick; // c9
        chk("t3_c9_m0rdv", a_m0_rdv, 1);

        // ---- abort: m1 drops read in ISSUE; last grant stays m0 so m1 wins the next tie
        a_m1_read = 1; a_m1_address = 0;
        tick; // c1 ISSUE
        a_m1_read = 0;
        tick; // c2 back in IDLE
        chk("t4_c2_m1wr", a_m1_wr, 1);
        a_m0_read = 1; a_m0_address = 0; a_m1_read = 1; a_m1_address = 0;
        tick; // c3
        chk("t4_c3_m1rdv", a_m1_rdv, 0);
        chk("t4_c3_m1hold", a_m1_rd, ID_WORD);
        tick; // c4
        chk("t4_c4_m1wr", a_m1_wr, 0);
        chk("t4_c4_m0wr", a_m0_wr, 1);
        a_m1_read = 0;
        tick; // c5
        chk("t4_c5_m1rdv", a_m1_rdv, 1);
        chk("t4_c5_m1data", a_m1_rd, 0);
        tick; tick; // c7
        chk("t4_c7_m0wr", a_m0_wr, 0);
        a_m0_read = 0;
        tick; // c8
        chk("t4_c8_m0rdv", a_m0_rdv, 1);
        chk("t4_c8_m0data", a_m0_rd, 0);

        // ---- streaming: m0 holds read for 8 reads, address alternating
        a_m0_read = 1;
        for (int k = 0; k < 8; k++) begin
            adr = (k % 2 == 0);
            a_m0_address = adr;
            tick;
            chk("t5_issue_rdv", a_m0_rdv, 0);
            tick;
            chk("t5_accept_wr", a_m0_wr, 0);
            if (k == 7) a_m0_read = 0;
            tick;
            chk("t5_rdv", a_m0_rdv, 1);
            chk("t5_data", a_m0_rd, adr ? ID_WORD : 32'h0);
        end
        tick;
        chk("t5_end_rdv", a_m0_rdv, 0);

        // ---- instance B, SLAVE_LATENCY=4: m1 reads address 1 then 0
        for (int r = 0; r < 2; r++) begin
            b_m1_read = 1; b_m1_address = (r == 0);
            chk("t6_c0_wr", b_m1_wr, 1);
            for (int c = 1; c <= 4; c++) begin
                tick;
                chk("t6_issue_wr", b_m1_wr, 1);
                chk("t6_issue_rdv", b_m1_rdv, 0);
            end
            tick; // c5
            chk("t6_c5_wr", b_m1_wr, 0);
            chk("t6_c5_rdv", b_m1_rdv, 0);
            b_m1_read = 0;
            tick; // c6
            chk("t6_c6_rdv", b_m1_rdv, 1);
            chk("t6_c6_data", b_m1_rd, (r == 0) ? ID_WORD : 32'h0);
            tick; // c7
            chk("t6_c7_rdv", b_m1_rdv, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
